// File: rtl/perf_counter_io.sv
// rtl/perf_counter_io.sv - memory-mapped event counters with CPU/memory pass-through
module perf_counter_io #(
  parameter int          NUM_CNT   = 8,
  parameter int          CNT_WIDTH = 32,
  parameter logic [15:0] BASE_ADDR = 16'hFFE0,
  parameter bit          SATURATE  = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_CNT-1:0] inc,
  input  logic               read,
  input  logic               write,
  input  logic [15:0]        address,
  input  logic [15:0]        wdata,
  output logic [15:0]        rdata,
  output logic               resp,
  output logic               read_pass,
  output logic               write_pass,
  output logic [15:0]        address_pass,
  output logic [15:0]        wdata_pass,
  input  logic [15:0]        rdata_pass,
  input  logic               resp_pass
);

  localparam int W      = CNT_WIDTH / 16;
  localparam int NWORDS = NUM_CNT * W;
  localparam int SHW    = (W > 1) ? CNT_WIDTH - 16 : 16;

  typedef enum logic {IDLE, RESP} state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q [NUM_CNT];
  logic [CNT_WIDTH-1:0] cnt_d [NUM_CNT];
  logic [SHW-1:0]       shadow_q, shadow_d;
  logic                 freeze_q, freeze_d;
  logic                 resp_q, resp_d;
  logic [15:0]          rdata_q, rdata_d;

  logic                 hit, is_ctrl, take, wr_ctrl, clear;
  logic [15:0]          off, k_idx, j_idx, rd_val;
  logic [CNT_WIDTH-1:0] cnt_sel;

  // 17-bit compare so a window ending at 16'hFFFF cannot wrap
  assign hit     = ({1'b0, address} >= {1'b0, BASE_ADDR}) &&
                   ({1'b0, address} <= ({1'b0, BASE_ADDR} + 17'(NWORDS)));
  assign off     = address - BASE_ADDR;
  assign k_idx   = off / 16'(W);
  assign j_idx   = off % 16'(W);
  assign is_ctrl = (off == 16'(NWORDS));

  always_comb begin
    cnt_sel = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (k_idx == 16'(i)) cnt_sel = cnt_q[i];
    end
    rd_val = '0;
    if (is_ctrl) begin
      rd_val = {15'b0, freeze_q};
    end else if (j_idx == 16'd0) begin
      rd_val = cnt_sel[15:0];
    end else begin
      for (int w = 1; w < W; w++) begin
        if (j_idx == 16'(w)) rd_val = shadow_q[(w-1)*16 +: 16];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    case (state_q)
      IDLE: begin
        if ((read || write) && hit) begin
          state_d = RESP;
          take    = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign wr_ctrl  = take && write && is_ctrl;
  assign clear    = wr_ctrl && wdata[1];
  assign freeze_d = wr_ctrl ? wdata[0] : freeze_q;
  assign resp_d   = take;
  assign rdata_d  = take ? rd_val : rdata_q;

  // Reading word 0 freezes the upper words so a multi-word read is coherent
  always_comb begin
    shadow_d = shadow_q;
    if (clear) begin
      shadow_d = '0;
    end else if (take && read && !is_ctrl && (j_idx == 16'd0)) begin
      shadow_d = SHW'(cnt_sel >> 16);
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CNT; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clear) begin
        cnt_d[i] = '0;
      end else if (inc[i] && !freeze_q) begin
        if (!(SATURATE && (&cnt_q[i]))) cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      freeze_q <= 1'b0;
      resp_q   <= 1'b0;
      rdata_q  <= '0;
      for (int i = 0; i < NUM_CNT; i++) cnt_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      freeze_q <= freeze_d;
      resp_q   <= resp_d;
      rdata_q  <= rdata_d;
      for (int i = 0; i < NUM_CNT; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign read_pass    = read && !hit;
  assign write_pass   = write && !hit;
  assign address_pass = address;
  assign wdata_pass   = wdata;
  assign rdata        = hit ? rdata_q : rdata_pass;
  assign resp         = hit ? resp_q : resp_pass;

endmodule

// File: tb/tb_perf_counter_io.sv
// tb/tb_perf_counter_io.sv - randomized and directed checks of perf_counter_io against a counter model
module tb_perf_counter_io;

  localparam logic [15:0] BASE = 16'hFFE0;
  localparam int          CTRL = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  inc = '0;
  logic        read = 1'b0, write = 1'b0;
  logic [15:0] address = BASE, wdata = '0, rdata_pass = '0;
  logic        resp_pass = 1'b0;

  logic [15:0] rdata, address_pass, wdata_pass;
  logic        resp, read_pass, write_pass;
  logic [15:0] w_rdata, w_address_pass, w_wdata_pass;
  logic        w_resp, w_read_pass, w_write_pass;
  logic [15:0] s_rdata, s_address_pass, s_wdata_pass;
  logic        s_resp, s_read_pass, s_write_pass;

  int total = 0;
  int bad   = 0;

  logic [63:0] m_cnt [8];
  logic        m_freeze = 1'b0;
  logic [15:0] m_shadow = '0;
  bit          p_wr = 1'b0;
  int          p_off = 0;
  logic [15:0] p_wdata = '0;
  logic [7:0]  inc_mask = '0;

  perf_counter_io dut (
    .clk(clk), .rst_n(rst_n), .inc(inc), .read(read), .write(write),
    .address(address), .wdata(wdata), .rdata(rdata), .resp(resp),
    .read_pass(read_pass), .write_pass(write_pass), .address_pass(address_pass),
    .wdata_pass(wdata_pass), .rdata_pass(rdata_pass), .resp_pass(resp_pass)
  );

  perf_counter_io #(.CNT_WIDTH(16), .SATURATE(1'b0)) dut_w (
    .clk(clk), .rst_n(rst_n), .inc(inc), .read(read), .write(write),
    .address(address), .wdata(wdata), .rdata(w_rdata), .resp(w_resp),
    .read_pass(w_read_pass), .write_pass(w_write_pass), .address_pass(w_address_pass),
    .wdata_pass(w_wdata_pass), .rdata_pass(rdata_pass), .resp_pass(resp_pass)
  );

  perf_counter_io #(.CNT_WIDTH(16), .SATURATE(1'b1)) dut_s (
    .clk(clk), .rst_n(rst_n), .inc(inc), .read(read), .write(write),
    .address(address), .wdata(wdata), .rdata(s_rdata), .resp(s_resp),
    .read_pass(s_read_pass), .write_pass(s_write_pass), .address_pass(s_address_pass),
    .wdata_pass(s_wdata_pass), .rdata_pass(rdata_pass), .resp_pass(resp_pass)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_cnt[i] = '0;
    m_freeze = 1'b0;
    m_shadow = '0;
    p_wr     = 1'b0;
  endtask

  // One clock: the model applies this cycle's events as the DUT does on the edge
  task automatic tick(input logic [7:0] incv);
    bit clr;
    inc = incv;
    @(posedge clk);
    clr = p_wr && (p_off == CTRL) && p_wdata[1];
    for (int i = 0; i < 8; i++) begin
      if (clr) m_cnt[i] = '0;
      else if (incv[i] && !m_freeze) m_cnt[i] = (m_cnt[i] + 64'd1) & 64'hFFFF_FFFF;
    end
    if (clr) m_shadow = '0;
    if (p_wr && (p_off == CTRL)) m_freeze = p_wdata[0];
    p_wr = 1'b0;
    #1;
  endtask

  task automatic access(input bit rd, input bit wr, input int off,
                        input logic [15:0] wd, input logic [7:0] incv);
    logic [15:0] exp;
    exp = '0;
    if (rd) begin
      if (off == CTRL) begin
        exp = {15'b0, m_freeze};
      end else if (off % 2 == 0) begin
        exp      = m_cnt[off/2][15:0];
        m_shadow = m_cnt[off/2][31:16];
      end else begin
        exp = m_shadow;
      end
    end
    address = BASE + 16'(off);
    read    = rd;
    write   = wr;
    wdata   = wd;
    if (wr) begin
      p_wr    = 1'b1;
      p_off   = off;
      p_wdata = wd;
    end
    tick(incv);
    chk("acc_resp", {31'b0, resp}, 32'd1);
    chk("acc_read_pass", {31'b0, read_pass}, 32'd0);
    chk("acc_write_pass", {31'b0, write_pass}, 32'd0);
    if (rd) chk($sformatf("rd_off%0d", off), {16'b0, rdata}, {16'b0, exp});
    read  = 1'b0;
    write = 1'b0;
    tick(8'($urandom) & inc_mask);
    chk("acc_idle_resp", {31'b0, resp}, 32'd0);
  endtask

  task automatic mread(input int off);
    access(1'b1, 1'b0, off, 16'h0000, 8'($urandom) & inc_mask);
  endtask

  task automatic mwrite(input int off, input logic [15:0] wd);
    access(1'b0, 1'b1, off, wd, 8'($urandom) & inc_mask);
  endtask

  initial begin
    model_reset();
    #12;
    chk("rst_resp", {31'b0, resp}, 32'd0);
    chk("rst_rdata", {16'b0, rdata}, 32'd0);
    rst_n = 1'b1;

    // Long preload of counter 0 to 16'hFFFF in all three instances
    for (int c = 0; c < 65535; c++) tick(8'h01);
    mread(0);
    tick(8'h01);
    mread(1);
    mread(0);
    chk("wrap16_rdata", {16'b0, w_rdata}, 32'h0000);
    chk("sat16_rdata", {16'b0, s_rdata}, 32'hFFFF);
    mread(1);
    mwrite(CTRL, 16'h0002);

    for (int c = 0; c < 5; c++) tick(8'h04);
    mread(4);

    for (int c = 0; c < 3; c++) tick(8'h01);
    mwrite(CTRL, 16'h0001);
    for (int c = 0; c < 10; c++) tick(8'h01);
    mread(0);
    mread(CTRL);
    mwrite(CTRL, 16'h0002);
    for (int i = 0; i < 8; i++) mread(2 * i);
    mread(CTRL);

    for (int c = 0; c < 4; c++) tick(8'hFF);
    access(1'b0, 1'b1, CTRL, 16'h0002, 8'hFF);
    mread(2);

    for (int c = 0; c < 3; c++) tick(8'h08);
    access(1'b1, 1'b1, CTRL, 16'h0001, 8'h00);
    mread(CTRL);
    mwrite(CTRL, 16'h0000);

    address    = BASE - 16'd1;
    read       = 1'b1;
    rdata_pass = 16'($urandom);
    resp_pass  = 1'b0;
    #1;
    chk("pass_read_pass", {31'b0, read_pass}, 32'd1);
    chk("pass_rdata", {16'b0, rdata}, {16'b0, rdata_pass});
    chk("pass_resp_lo", {31'b0, resp}, 32'd0);
    resp_pass = 1'b1;
    #1;
    chk("pass_resp_hi", {31'b0, resp}, 32'd1);
    tick(8'h00);
    read  = 1'b0;
    write = 1'b1;
    wdata = 16'($urandom);
    #1;
    chk("pass_write_pass", {31'b0, write_pass}, 32'd1);
    chk("pass_address", {16'b0, address_pass}, {16'b0, address});
    chk("pass_wdata", {16'b0, wdata_pass}, {16'b0, wdata});
    write     = 1'b0;
    resp_pass = 1'b0;
    mread(6);

    inc_mask = 8'hFF;
    for (int it = 0; it < 40; it++) begin
      int k;
      k = int'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0: for (int c = 0; c < int'($urandom_range(1, 20)); c++) tick(8'($urandom));
        1: begin mread(2 * k); mread(2 * k + 1); end
        2: mread(CTRL);
        3: mwrite(CTRL, 16'($urandom_range(0, 3)));
        4: mread(2 * k + 1);
        default: begin mwrite(2 * k, 16'($urandom)); mread(2 * k); end
      endcase
    end
    inc_mask = 8'h00;

    address = BASE;
    read    = 1'b1;
    tick(8'h00);
    chk("mid_resp_before", {31'b0, resp}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_resp_reset", {31'b0, resp}, 32'd0);
    read = 1'b0;
    model_reset();
    #2;
    rst_n = 1'b1;
    mread(0);
    mread(CTRL);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
